// File: rtl/mux_stage_pkg.sv
// Shared types and constants for the operand staging stage feeding the
// adiabatic 2:1 operand mux.
package mux_stage_pkg;

    localparam int ALU_W = 16;

    typedef enum logic {
        IDLE,
        HOLD
    } stager_state_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             sel;
    } operand_t;

endpackage

// File: rtl/stage_fifo.sv
// Synchronous FIFO buffering operand triples ahead of the mux hold sequencer.
// A pushed entry only becomes poppable one edge after it is written.
module stage_fifo #(
    parameter int DW    = 33,
    parameter int DEPTH = 2,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clkpos,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   wptr_q;

    // wptr_q lags wptr by one edge so a fresh write is never read in the
    // cycle it lands, giving the two-edge minimum latency to the mux.
    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            wptr_q <= '0;
        end else begin
            if (push && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
            wptr_q <= wptr;
        end
    end

    always_ff @(posedge clkpos) begin
        if (push && !full) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr_q == rptr);
    assign level = LW'(wptr - rptr);

endmodule

// File: rtl/mux_operand_stager.sv
// Buffers {a, b, select} triples and holds each on registered mux inputs for
// HOLD cycles, flagging the last hold cycle with done.
module mux_operand_stager
    import mux_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int HOLD  = 2
) (
    input  logic                         clkpos,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_a,
    input  logic [WIDTH-1:0]             s_b,
    input  logic                         s_sel,
    output logic [WIDTH-1:0]             a,
    output logic [WIDTH-1:0]             b,
    output logic                         in,
    output logic                         hold_active,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int DW = 2 * WIDTH + 1;
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    // The HOLD parameter shadows the enum literal, so states are always
    // named through the package.
    stager_state_t state;
    stager_state_t state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DW-1:0] head;

    assign s_ready = !full;
    assign push    = s_valid && !full;

    stage_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .LW    ($clog2(DEPTH + 1))
    ) u_fifo (
        .clkpos (clkpos),
        .rst_n  (rst_n),
        .push   (push),
        .pop    (pop),
        .wdata  ({s_a, s_b, s_sel}),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        case (state)
            mux_stage_pkg::IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cnt_nxt   = CW'(HOLD - 1);
                    state_nxt = mux_stage_pkg::HOLD;
                end
            end
            mux_stage_pkg::HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (!empty) begin
                    pop     = 1'b1;
                    cnt_nxt = CW'(HOLD - 1);
                end else begin
                    state_nxt = mux_stage_pkg::IDLE;
                end
            end
            default: begin
                state_nxt = mux_stage_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            state <= mux_stage_pkg::IDLE;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            in    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (pop) begin
                {a, b, in} <= head;
            end
        end
    end

    assign hold_active = (state == mux_stage_pkg::HOLD);
    assign done        = hold_active && (cnt == '0);

endmodule

// File: tb/tb_mux_operand_stager.sv
// Self-checking bench: three stager configurations share one random/directed
// stimulus stream and are compared every cycle against a timestamped queue model.
module tb_mux_operand_stager;

    localparam int W  = 16;
    localparam int NI = 3;

    logic clkpos = 1'b0;
    always #5 clkpos = ~clkpos;

    logic         rst_n;
    logic         s_valid;
    logic         s_sel;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;

    logic         rdy0, rdy1, rdy2;
    logic [W-1:0] a0, b0, a1, b1, a2, b2;
    logic         in0, in1, in2;
    logic         h0, h1, h2;
    logic         d0, d1, d2;
    logic [1:0]   lv0, lv1;
    logic [2:0]   lv2;

    mux_operand_stager #(.WIDTH(W), .DEPTH(2), .HOLD(2)) u0 (
        .clkpos(clkpos), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy0),
        .s_a(s_a), .s_b(s_b), .s_sel(s_sel), .a(a0), .b(b0), .in(in0),
        .hold_active(h0), .done(d0), .level(lv0));

    mux_operand_stager #(.WIDTH(W), .DEPTH(2), .HOLD(4)) u1 (
        .clkpos(clkpos), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy1),
        .s_a(s_a), .s_b(s_b), .s_sel(s_sel), .a(a1), .b(b1), .in(in1),
        .hold_active(h1), .done(d1), .level(lv1));

    mux_operand_stager #(.WIDTH(W), .DEPTH(4), .HOLD(1)) u2 (
        .clkpos(clkpos), .rst_n(rst_n), .s_valid(s_valid), .s_ready(rdy2),
        .s_a(s_a), .s_b(s_b), .s_sel(s_sel), .a(a2), .b(b2), .in(in2),
        .hold_active(h2), .done(d2), .level(lv2));

    function automatic int hold_of(int i);
        case (i)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int depth_of(int i);
        return (i == 2) ? 4 : 2;
    endfunction

    function automatic logic ready_of(int i);
        case (i)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    int checks = 0;
    int passes = 0;

    task automatic check_output(input string nm, input int i,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s u%0d: got 0x%0h, expected 0x%0h", nm, i, act, exp);
    endtask

    // Model: each accepted triple carries its accept-edge number; it may be
    // popped two or more edges later, and only when the mux is idle or in its
    // last hold cycle. rem counts hold cycles left including the current one.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sel;
        int           t;
    } entry_t;

    entry_t       mq [NI][$];
    logic [W-1:0] ma [NI];
    logic [W-1:0] mb [NI];
    logic         ms [NI];
    int           rem [NI];
    int           cyc = 0;
    entry_t       me;
    logic         m_acc;
    logic         m_pop;

    always @(posedge clkpos or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                mq[i].delete();
                ma[i]  = '0;
                mb[i]  = '0;
                ms[i]  = 1'b0;
                rem[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                m_acc = s_valid && (mq[i].size() < depth_of(i));
                m_pop = (mq[i].size() > 0) && (mq[i][0].t <= cyc - 2) && (rem[i] <= 1);
                if (m_pop) begin
                    me     = mq[i].pop_front();
                    ma[i]  = me.a;
                    mb[i]  = me.b;
                    ms[i]  = me.sel;
                    rem[i] = hold_of(i);
                end else if (rem[i] > 0) begin
                    rem[i]--;
                end
                if (m_acc) begin
                    me.a = s_a; me.b = s_b; me.sel = s_sel; me.t = cyc;
                    mq[i].push_back(me);
                end
            end
        end
    end

    task automatic cmp(input int i, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xin, input logic xh, input logic xd,
                       input logic [31:0] xl, input logic xr);
        check_output("a", i, 32'(xa), 32'(ma[i]));
        check_output("b", i, 32'(xb), 32'(mb[i]));
        check_output("in", i, 32'(xin), 32'(ms[i]));
        check_output("hold_active", i, 32'(xh), 32'(rem[i] > 0));
        check_output("done", i, 32'(xd), 32'(rem[i] == 1));
        check_output("level", i, xl, 32'(mq[i].size()));
        check_output("s_ready", i, 32'(xr), 32'(mq[i].size() < depth_of(i)));
    endtask

    int          dcnt [NI] = '{0, 0, 0};
    int          run2 = 0;
    int          maxrun2 = 0;
    logic        rec_on = 1'b0;
    logic        saw_full = 1'b0;
    logic [32:0] rec [$];

    always @(negedge clkpos) begin
        cmp(0, a0, b0, in0, h0, d0, 32'(lv0), rdy0);
        cmp(1, a1, b1, in1, h1, d1, 32'(lv1), rdy1);
        cmp(2, a2, b2, in2, h2, d2, 32'(lv2), rdy2);
        if (d0) dcnt[0]++;
        if (d1) dcnt[1]++;
        if (d2) dcnt[2]++;
        run2 = d2 ? run2 + 1 : 0;
        if (run2 > maxrun2) maxrun2 = run2;
        if (rec_on && d1) rec.push_back({a1, b1, in1});
        if (rec_on && !rdy1) saw_full = 1'b1;
    end

    task automatic tick();
        @(posedge clkpos);
        #1;
    endtask

    // Presents one triple and holds it until instance i accepts it.
    task automatic apply_stimulus(input int i, input logic [W-1:0] va,
                                  input logic [W-1:0] vb, input logic vs);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_a     = va;
        s_b     = vb;
        s_sel   = vs;
        for (int n = 0; n < 40 && !ok; n++) begin
            ok = ready_of(i);
            tick();
        end
        if (!ok) check_output("push_timeout", i, 32'd0, 32'd1);
    endtask

    logic [32:0] bp_exp [8];
    int          base;
    logic        waited;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_a = '0; s_b = '0; s_sel = 1'b0;
        repeat (3) @(posedge clkpos);
        #1 rst_n = 1'b1;
        check_output("rst_a", 0, 32'(a0), 32'h0);
        check_output("rst_ready", 0, 32'(rdy0), 32'h1);
        check_output("rst_level", 0, 32'(lv0), 32'h0);
        tick();

        // Single triple: accepted at edge k, mux inputs change at k+2.
        s_valid = 1'b1; s_a = 16'h1234; s_b = 16'hABCD; s_sel = 1'b1;
        tick();
        s_valid = 1'b0;
        check_output("single_level_k", 0, 32'(lv0), 32'h1);
        check_output("single_a_k", 0, 32'(a0), 32'h0);
        tick();
        check_output("single_a_k1", 0, 32'(a0), 32'h0);
        check_output("single_hold_k1", 0, 32'(h0), 32'h0);
        tick();
        check_output("single_a_k2", 0, 32'(a0), 32'h1234);
        check_output("single_b_k2", 0, 32'(b0), 32'hABCD);
        check_output("single_in_k2", 0, 32'(in0), 32'h1);
        check_output("single_hold_k2", 0, 32'(h0), 32'h1);
        check_output("single_done_k2", 0, 32'(d0), 32'h0);
        check_output("model_a_k2", 0, 32'(ma[0]), 32'h1234);
        tick();
        check_output("single_hold_k3", 0, 32'(h0), 32'h1);
        check_output("single_done_k3", 0, 32'(d0), 32'h1);
        check_output("model_done_k3", 0, 32'(rem[0] == 1), 32'h1);
        tick();
        check_output("single_hold_k4", 0, 32'(h0), 32'h0);
        check_output("single_done_k4", 0, 32'(d0), 32'h0);
        check_output("single_a_k4", 0, 32'(a0), 32'h1234);
        repeat (10) tick();

        // Back-to-back three triples on the HOLD=2 instance.
        base = dcnt[0];
        apply_stimulus(0, 16'h1111, 16'h2222, 1'b0);
        apply_stimulus(0, 16'h3333, 16'h4444, 1'b1);
        apply_stimulus(0, 16'h5555, 16'h6666, 1'b0);
        s_valid = 1'b0;
        repeat (14) tick();
        check_output("b2b_done_pulses", 0, 32'(dcnt[0] - base), 32'd3);
        check_output("b2b_last_a", 0, 32'(a0), 32'h5555);

        // HOLD=1: four consecutive triples give four consecutive done cycles.
        base = dcnt[2];
        maxrun2 = 0;
        for (int j = 0; j < 4; j++) apply_stimulus(2, 16'(16'h0A00 + j), 16'(16'h0B00 + j), j[0]);
        s_valid = 1'b0;
        repeat (20) tick();
        check_output("h1_done_pulses", 2, 32'(dcnt[2] - base), 32'd4);
        check_output("h1_done_run", 2, 32'(maxrun2), 32'd4);
        check_output("h1_last_a", 2, 32'(a2), 32'h0A03);

        // Backpressure on DEPTH=2/HOLD=4: order kept across pointer wrap.
        rec.delete();
        saw_full = 1'b0;
        rec_on   = 1'b1;
        for (int j = 0; j < 8; j++) begin
            bp_exp[j] = {16'($urandom), 16'($urandom), 1'($urandom)};
            apply_stimulus(1, bp_exp[j][32:17], bp_exp[j][16:1], bp_exp[j][0]);
        end
        s_valid = 1'b0;
        repeat (45) tick();
        rec_on = 1'b0;
        check_output("bp_saw_full", 1, 32'(saw_full), 32'h1);
        check_output("bp_count", 1, 32'(rec.size()), 32'd8);
        for (int j = 0; j < 8 && j < rec.size(); j++)
            check_output("bp_order", 1, 32'(rec[j]), 32'(bp_exp[j]));

        // Random traffic, checked by the per-cycle compare.
        for (int n = 0; n < 400; n++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_a     = 16'($urandom);
            s_b     = 16'($urandom);
            s_sel   = 1'($urandom);
            tick();
        end
        s_valid = 1'b0;
        repeat (30) tick();

        // Reset during the first HOLD cycle with one triple still queued.
        apply_stimulus(0, 16'hC0DE, 16'hBEEF, 1'b1);
        apply_stimulus(0, 16'hFACE, 16'hD00D, 1'b0);
        s_valid = 1'b0;
        waited  = 1'b0;
        for (int n = 0; n < 20 && !waited; n++) begin
            if (h0) waited = 1'b1;
            else tick();
        end
        check_output("rmid_reached_hold", 0, 32'(waited), 32'h1);
        check_output("rmid_level", 0, 32'(lv0), 32'h1);
        check_output("rmid_a_before", 0, 32'(a0), 32'hC0DE);
        #2 rst_n = 1'b0;
        #1;
        check_output("rmid_a", 0, 32'(a0), 32'h0);
        check_output("rmid_b", 0, 32'(b0), 32'h0);
        check_output("rmid_in", 0, 32'(in0), 32'h0);
        check_output("rmid_hold", 0, 32'(h0), 32'h0);
        check_output("rmid_done", 0, 32'(d0), 32'h0);
        check_output("rmid_lvl", 0, 32'(lv0), 32'h0);
        check_output("rmid_ready", 0, 32'(rdy0), 32'h1);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check_output("post_rst_a", 0, 32'(a0), 32'h0);
        check_output("post_rst_hold", 0, 32'(h0), 32'h0);
        check_output("post_rst_level", 0, 32'(lv0), 32'h0);
        apply_stimulus(0, 16'h7777, 16'h8888, 1'b1);
        s_valid = 1'b0;
        repeat (3) tick();
        check_output("post_rst_new_a", 0, 32'(a0), 32'h7777);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
